// File: rtl/vid_sprite_pkg.sv
// ---------------------------------------------------------------------------
// vid_sprite_pkg
// Shared definitions for the sprite line buffer read side: line buffer port
// geometry, scan-out state encoding and the transparent pixel value.
// ---------------------------------------------------------------------------
package vid_sprite_pkg;

    localparam int LB_ADDR_W = 11;   // {bank, x[9:0]}
    localparam int LB_DATA_W = 9;
    localparam int LB_X_W    = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

    localparam logic [LB_DATA_W-1:0] TRANSPARENT = 9'h000;

endpackage

// File: rtl/vid_sprite_linebuf_scanout_if.sv
// ---------------------------------------------------------------------------
// vid_sprite_linebuf_scanout_if
// Port B of the 2048x9 sprite line buffer RAM.
//   lb_en    : port clock enable
//   lb_wr    : port write enable (read-before-write RAM)
//   lb_addr  : {bank, x}
//   lb_wdata : write data
//   lb_rdata : registered read data, valid one cycle after lb_en
// master = scan-out controller, slave = RAM.
// ---------------------------------------------------------------------------
interface vid_sprite_linebuf_scanout_if;
    import vid_sprite_pkg::*;

    logic                 lb_en;
    logic                 lb_wr;
    logic [LB_ADDR_W-1:0] lb_addr;
    logic [LB_DATA_W-1:0] lb_wdata;
    logic [LB_DATA_W-1:0] lb_rdata;

    modport master (
        output lb_en, lb_wr, lb_addr, lb_wdata,
        input  lb_rdata
    );

    modport slave (
        input  lb_en, lb_wr, lb_addr, lb_wdata,
        output lb_rdata
    );
endinterface

// File: rtl/vid_sprite_scanout_pipe.sv
// ---------------------------------------------------------------------------
// vid_sprite_scanout_pipe
// Two-stage valid/data pipeline that aligns the request valid with the RAM's
// registered read data and registers the pixel for the mixer.
//   clk, reset_n : pixel clock, async active-low reset
//   i_vld        : a RAM read was issued this cycle
//   i_rdata      : RAM read data (belongs to the read issued last cycle)
//   o_pix        : registered pixel, zero when o_vld is low
//   o_vld        : o_pix valid
//   o_empty      : no read in flight and no pixel on the output
// ---------------------------------------------------------------------------
module vid_sprite_scanout_pipe #(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_pix,
    output logic              o_vld,
    output logic              o_empty
);

    logic              r_vld_p1;
    logic              r_vld_p2;
    logic [DATA_W-1:0] r_pix_p2;

    // p1: read data is on the RAM output during this stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= i_vld;
        end
    end

    // p2: registered pixel towards the mixer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p2 <= 1'b0;
            r_pix_p2 <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            r_pix_p2 <= r_vld_p1 ? i_rdata : '0;
        end
    end

    assign o_pix   = r_pix_p2;
    assign o_vld   = r_vld_p2;
    assign o_empty = ~r_vld_p1 & ~r_vld_p2;

endmodule

// File: rtl/vid_sprite_linebuf_scanout.sv
// ---------------------------------------------------------------------------
// vid_sprite_linebuf_scanout
// Streams one bank of the double-banked sprite line buffer to the pixel mixer,
// one pixel per pix_req, while the renderer fills the other bank.
//
// Build option VID_SPRITE_LINEBUF_CLEAR_EN: when defined, every read also
// writes CLEAR_VAL to the same entry (read-before-write RAM returns the old
// value), leaving the bank transparent for the renderer. When undefined the
// block only reads and lb_wr is tied low.
//
// Ports:
//   clk, reset_n  : pixel clock, asynchronous active-low reset
//   line_start    : one-cycle pulse per visible line, swaps banks
//   pix_req       : consume one pixel this cycle
//   bank          : bank being scanned out (renderer writes bank ^ 1)
//   lb            : line buffer port B (master side)
//   pix_out       : pixel to the mixer, zero when pix_valid is low
//   pix_valid     : pix_out valid (2 cycles after pix_req)
//   line_done     : pulse in the cycle after the last pixel of a line
//   err_overrun   : sticky, pix_req seen with no line active
// ---------------------------------------------------------------------------
module vid_sprite_linebuf_scanout
    import vid_sprite_pkg::*;
#(
    parameter int                    LINE_W    = 480,
    parameter logic [LB_DATA_W-1:0]  CLEAR_VAL = TRANSPARENT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        line_start,
    input  logic                        pix_req,
    output logic                        bank,
    vid_sprite_linebuf_scanout_if.master lb,
    output logic [LB_DATA_W-1:0]        pix_out,
    output logic                        pix_valid,
    output logic                        line_done,
    output logic                        err_overrun
);

    localparam logic [1:0]        S_IDLE  = ST_IDLE;
    localparam logic [1:0]        S_SCAN  = ST_SCAN;
    localparam logic [1:0]        S_DRAIN = ST_DRAIN;
    localparam logic [LB_X_W-1:0] X_LAST  = LB_X_W'(LINE_W - 1);

    logic [1:0]        r_state;
    logic [LB_X_W-1:0] r_x;
    logic              r_bank;
    logic              r_err;

    logic              w_scan_act;
    logic              w_cur_bank;
    logic [LB_X_W-1:0] w_cur_x;
    logic              w_rd;
    logic              w_last;
    logic              w_pipe_empty;

    // line_start takes effect in its own cycle: a request arriving with it
    // reads the new bank at x = 0.
    always_comb begin
        w_scan_act = line_start | (r_state == S_SCAN);
        w_cur_bank = line_start ? ~r_bank : r_bank;
        w_cur_x    = line_start ? '0 : r_x;
        w_rd       = w_scan_act & pix_req;
        w_last     = (w_cur_x == X_LAST);
    end

    assign lb.lb_en    = w_rd;
    assign lb.lb_addr  = {w_cur_bank, w_cur_x};
    assign lb.lb_wdata = CLEAR_VAL;
`ifdef VID_SPRITE_LINEBUF_CLEAR_EN
    assign lb.lb_wr    = w_rd;
`else
    assign lb.lb_wr    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_bank  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (pix_req && !w_scan_act) begin
                r_err <= 1'b1;
            end
            if (line_start) begin
                r_bank <= ~r_bank;
            end
            if (w_rd) begin
                if (w_last) begin
                    r_state <= S_DRAIN;
                end else begin
                    r_state <= S_SCAN;
                    r_x     <= w_cur_x + 1'b1;
                end
            end else if (line_start) begin
                r_state <= S_SCAN;
                r_x     <= '0;
            end else if (r_state == S_DRAIN && w_pipe_empty) begin
                r_state <= S_IDLE;
            end
        end
    end

    vid_sprite_scanout_pipe #(
        .DATA_W (LB_DATA_W)
    ) u_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_vld   (w_rd),
        .i_rdata (lb.lb_rdata),
        .o_pix   (pix_out),
        .o_vld   (pix_valid),
        .o_empty (w_pipe_empty)
    );

    // An abort landing on the drain's final cycle suppresses line_done.
    assign line_done   = (r_state == S_DRAIN) & w_pipe_empty & ~line_start;
    assign bank        = r_bank;
    assign err_overrun = r_err;

endmodule

// File: tb/tb_vid_sprite_linebuf_scanout.sv
module tb_vid_sprite_linebuf_scanout;
    import vid_sprite_pkg::*;

    localparam int         LINE_W    = 480;
    localparam logic [8:0] CLEAR_VAL = 9'h000;
`ifdef VID_SPRITE_LINEBUF_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] d;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       line_start = 1'b0;
    logic       pix_req = 1'b0;
    logic       bank;
    logic [8:0] pix_out;
    logic       pix_valid;
    logic       line_done;
    logic       err_overrun;

    vid_sprite_linebuf_scanout_if lb();

    vid_sprite_linebuf_scanout #(
        .LINE_W    (LINE_W),
        .CLEAR_VAL (CLEAR_VAL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .line_start  (line_start),
        .pix_req     (pix_req),
        .bank        (bank),
        .lb          (lb),
        .pix_out     (pix_out),
        .pix_valid   (pix_valid),
        .line_done   (line_done),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read, read-before-write, plus a bulk-load path
    logic [8:0] mem [2048];
    logic       load_go = 1'b0;
    logic       load_b = 1'b0;
    int         load_seed = 0;

    function automatic logic [8:0] pat(input logic b, input int i, input int seed);
        return b ? 9'(i + seed) : 9'(i * 7 + 3 + seed);
    endfunction

    always @(posedge clk) begin
        if (load_go) begin
            for (int i = 0; i < 1024; i++) mem[{load_b, 10'(i)}] <= pat(load_b, i, load_seed);
        end else if (lb.lb_en) begin
            lb.lb_rdata <= mem[lb.lb_addr];
            if (lb.lb_wr) mem[lb.lb_addr] <= lb.lb_wdata;
        end
    end

    logic [8:0] exp_mem [2048];
    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         ld_count = 0;
    int         ld_cyc = 0;
    int         last_req_cyc = 0;
    bit         mon_on = 1'b0;
    logic       tb_bank = 1'b0;
    logic [9:0] tb_x = '0;
    bit         tb_scan = 1'b0;

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (line_done) begin
                    ld_count++;
                    ld_cyc = cyc;
                end
                checks++;
                if (pix_valid) begin
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pixel: got %h at cycle %0d, required none", pix_out, cyc);
                    end else begin
                        e = q.pop_front();
                        if (pix_out !== e.d || cyc !== e.c + 2) begin
                            errors++;
                            $display("FAIL pixel: got %h at cycle %0d, required %h at cycle %0d",
                                     pix_out, cyc, e.d, e.c + 2);
                        end
                    end
                end else if (pix_out !== 9'h000) begin
                    errors++;
                    $display("FAIL pix_out_idle: got %h, required 000", pix_out);
                end
            end
        end
    endtask

    task automatic load_bank(input logic b, input int seed);
        load_b = b;
        load_seed = seed;
        load_go = 1'b1;
        for (int i = 0; i < 1024; i++) exp_mem[{b, 10'(i)}] = pat(b, i, seed);
        @(posedge clk); #1;
        load_go = 1'b0;
    endtask

    // One cycle of stimulus, with the address/enable check for that cycle
    task automatic drive(input logic req, input logic ls);
        logic [10:0] a;
        bit act;
        pix_req = req;
        line_start = ls;
        act = ls || tb_scan;
        if (ls) begin
            tb_bank = ~tb_bank;
            tb_x = '0;
            tb_scan = 1'b1;
        end
        #1;
        checks++;
        if (req && act) begin
            a = {tb_bank, tb_x};
            if (lb.lb_en !== 1'b1 || lb.lb_addr !== a || lb.lb_wr !== CLR) begin
                errors++;
                $display("FAIL read_access: got en=%b wr=%b addr=%h, required en=1 wr=%b addr=%h",
                         lb.lb_en, lb.lb_wr, lb.lb_addr, CLR, a);
            end
            q.push_back('{d: exp_mem[a], c: cyc});
            last_req_cyc = cyc;
            if (CLR) exp_mem[a] = CLEAR_VAL;
            if (tb_x == 10'(LINE_W - 1)) tb_scan = 1'b0;
            else tb_x = tb_x + 1'b1;
        end else if (lb.lb_en !== 1'b0 || lb.lb_wr !== 1'b0) begin
            errors++;
            $display("FAIL no_access: got en=%b wr=%b, required en=0 wr=0", lb.lb_en, lb.lb_wr);
        end
        @(posedge clk); #1;
        pix_req = 1'b0;
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget);
        int n = 0;
        while (ld_count == start && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ld_count !== start + 1) begin
            errors++;
            $display("FAIL line_done_count: got %0d pulses, required 1", ld_count - start);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pixels_missing: got %0d outstanding, required 0", q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bank !== 1'b0 || lb.lb_en !== 1'b0 || lb.lb_wr !== 1'b0 || lb.lb_addr !== 11'h000 ||
            lb.lb_wdata !== CLEAR_VAL || pix_out !== 9'h000 || pix_valid !== 1'b0 ||
            line_done !== 1'b0 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got bank=%b en=%b wr=%b addr=%h wd=%h pix=%h v=%b ld=%b err=%b, required all 0 wd=%h",
                     bank, lb.lb_en, lb.lb_wr, lb.lb_addr, lb.lb_wdata, pix_out, pix_valid,
                     line_done, err_overrun, CLEAR_VAL);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        mon_on = 1'b1;
    endtask

    task automatic test_overrun();
        checks++;
        if (err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL err_before: got %b, required 0", err_overrun);
        end
        repeat (3) drive(1'b1, 1'b0);
        checks++;
        if (err_overrun !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b, required 1", err_overrun);
        end
    endtask

    task automatic test_full_line();
        int s = ld_count;
        drive(1'b0, 1'b1);
        for (int i = 0; i < LINE_W; i++) drive(1'b1, 1'b0);
        wait_done(s, 20);
        checks++;
        if (ld_cyc !== last_req_cyc + 3) begin
            errors++;
            $display("FAIL line_done_time: got cycle %0d, required %0d", ld_cyc, last_req_cyc + 3);
        end
        checks++;
        if (bank !== 1'b1) begin
            errors++;
            $display("FAIL bank_after_line: got %b, required 1", bank);
        end
        checks++;
        if (err_overrun !== 1'b1) begin
            errors++;
            $display("FAIL err_held: got %b, required 1", err_overrun);
        end
    endtask

    task automatic test_clear_rescan();
        int s = ld_count;
        logic [8:0] want;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        for (int i = 0; i < LINE_W; i++) drive(1'b1, 1'b0);
        wait_done(s, 20);
        want = CLR ? 9'h000 : 9'h005;
        checks++;
        if (mem[11'h405] !== want) begin
            errors++;
            $display("FAIL bank1_entry5: got %h, required %h", mem[11'h405], want);
        end
    endtask

    task automatic test_gapped();
        int s = ld_count;
        drive(1'b0, 1'b1);
        for (int i = 0; i < LINE_W; i++) begin
            drive(1'b1, 1'b0);
            drive(1'b0, 1'b0);
            drive(1'b0, 1'b0);
        end
        wait_done(s, 20);
        checks++;
        if (bank !== 1'b0) begin
            errors++;
            $display("FAIL bank_gapped: got %b, required 0", bank);
        end
    endtask

    task automatic test_abort();
        int s;
        logic [8:0] w199;
        load_bank(1'b1, 100);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) drive(1'b1, 1'b0);
        s = ld_count;
        drive(1'b1, 1'b1);
        for (int i = 1; i < LINE_W; i++) drive(1'b1, 1'b0);
        wait_done(s, 20);
        checks++;
        if (bank !== 1'b0) begin
            errors++;
            $display("FAIL bank_abort: got %b, required 0", bank);
        end
        checks++;
        if (mem[11'h400 + 200] !== pat(1'b1, 200, 100) || mem[11'h400 + 479] !== pat(1'b1, 479, 100)) begin
            errors++;
            $display("FAIL aborted_kept: got %h %h, required %h %h", mem[11'h400 + 200],
                     mem[11'h400 + 479], pat(1'b1, 200, 100), pat(1'b1, 479, 100));
        end
        w199 = CLR ? CLEAR_VAL : pat(1'b1, 199, 100);
        checks++;
        if (mem[11'h400 + 199] !== w199) begin
            errors++;
            $display("FAIL aborted_read_entry: got %h, required %h", mem[11'h400 + 199], w199);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) drive(1'b1, 1'b0);
        pix_req = 1'b1;
        #2;
        reset_n = 1'b0;
        q.delete();
        tb_bank = 1'b0;
        tb_scan = 1'b0;
        #1;
        checks++;
        if (bank !== 1'b0 || lb.lb_en !== 1'b0 || lb.lb_wr !== 1'b0 || lb.lb_addr !== 11'h000 ||
            pix_out !== 9'h000 || pix_valid !== 1'b0 || line_done !== 1'b0 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got bank=%b en=%b wr=%b addr=%h pix=%h v=%b ld=%b err=%b, required all 0",
                     bank, lb.lb_en, lb.lb_wr, lb.lb_addr, pix_out, pix_valid, line_done, err_overrun);
        end
        pix_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b0);
        checks++;
        if (err_overrun !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: got err=%b, required 1", err_overrun);
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        load_bank(1'b0, 0);
        load_bank(1'b1, 0);
        test_reset();
        test_overrun();
        test_full_line();
        test_clear_rescan();
        test_gapped();
        test_abort();
        test_async_reset();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vid_sprite_linebuf_scanout.md
# vid_sprite_linebuf_scanout

Read-side controller for the double-banked sprite line buffer: while the sprite renderer fills one bank for the next line, this block streams the other bank out to the video mixer one pixel per request and clears each entry behind itself so the bank is empty when the renderer gets it back. It connects to port B of the 2048x9 sprite line buffer RAM and sits between the video timing generator and the pixel mixer.

## Interface
Parameters:
- LINE_W, 480, visible pixels per line; 1..1024
- CLEAR_VAL, 9'h000, value written behind each read (transparent pixel)

Ports:
- clk  in  1  video pixel clock
- reset_n  in  1  asynchronous, active-low reset
- line_start  in  1  one-cycle pulse at start of each visible line; swaps banks
- pix_req  in  1  consume one pixel this cycle
- bank  out  1  bank being scanned out; renderer writes bank ^ 1
- lb_en  out  1  line buffer port clock enable
- lb_wr  out  1  line buffer port write enable
- lb_addr  out  11  {bank, x[9:0]}
- lb_wdata  out  9  always CLEAR_VAL
- lb_rdata  in  9  line buffer port read data (registered in RAM, 1 cycle)
- pix_out  out  9  pixel to mixer
- pix_valid  out  1  pix_out is valid this cycle
- line_done  out  1  one-cycle pulse after last pixel of the line is emitted
- err_overrun  out  1  sticky: pix_req arrived with no line active

## Operation
- States: IDLE, SCAN, DRAIN. Reset -> IDLE.
- IDLE: wait for line_start. line_start -> bank toggles, x = 0, go SCAN.
- SCAN: each cycle with pix_req: lb_en = 1, lb_addr = {bank, x}, x++. When x reaches LINE_W-1 with pix_req -> DRAIN. Cycles without pix_req: lb_en = 0, x holds.
- DRAIN: wait for the 2-deep read pipeline to empty; then pulse line_done, go IDLE.
- RAM port is read-before-write: a combined read+write at one address returns the old value. Clear-behind uses this: lb_wr = lb_en on every read, clearing the entry in the same access.
- line_start in SCAN or DRAIN: abort current line; bank toggles, x = 0, go SCAN. In-flight pixels still emitted with pix_valid; no line_done for the aborted line. Unread entries of the aborted bank are not cleared.
- line_start in same cycle as pix_req: the pixel is read from the new bank at x = 0.
- pix_req in IDLE or DRAIN: ignored (no RAM access), err_overrun set; cleared only by reset.
- x is 10 bits; never wraps, as SCAN exits at LINE_W-1.
- pix_out = 0 whenever pix_valid = 0.

## Timing
- Reset values: bank 0, lb_en 0, lb_wr 0, lb_addr 0, lb_wdata CLEAR_VAL, pix_out 0, pix_valid 0, line_done 0, err_overrun 0.
- lb_en/lb_wr/lb_addr combinational from state, x, bank, pix_req.
- pix_req at cycle t -> lb_rdata valid at t+1 -> pix_out/pix_valid registered at t+2. Latency 2, throughput 1 pixel/cycle.
- Bank toggles on the edge that samples line_start.
- line_done is asserted in the cycle after the last pix_valid of the line.

## Configuration
- VID_SPRITE_LINEBUF_CLEAR_EN defined: clear-behind as above.
- Not defined: lb_wr tied 0; the block only reads; the renderer clears banks itself. All other behaviour identical.

## Structure
- Shared package vid_sprite_pkg: LB_ADDR_W = 11, LB_DATA_W = 9, LB_X_W = 10, the state enum (IDLE, SCAN, DRAIN), default transparent value.
- One natural sub-module: vid_sprite_scanout_pipe, the 2-stage valid/data shift pipeline with in-flight-empty flag used by DRAIN.

## Test plan
- Preload bank 1 addr 0..479 with addr[8:0]; reset, line_start, 480 back-to-back pix_req -> pix_out 0..479 in order, first pix_valid 2 cycles after first pix_req, line_done once, bank = 1.
- Same line with clear enabled, then line_start twice and rescan bank 1 -> all pixels 9'h000; with macro undefined -> original values returned.
- pix_req gapped (1 on, 2 off) -> pixel order intact, no duplicates, lb_en only on request cycles.
- line_start at x = 200 -> bank toggles, next read at {new bank, 0}, 2 in-flight pixels still valid, no line_done; bank entries 200..479 keep contents.
- pix_req in IDLE after reset -> no lb_en, err_overrun = 1 and held until reset_n low.
- reset_n asserted mid-SCAN (async, between edges) -> all outputs immediately at reset values, state IDLE, bank 0.
